// File: rtl/cmp_pkg.sv
// Shared types and result encoding for the serial magnitude comparator.
// Results are packed as {eq, lt, gt}.
package cmp_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompare = 2'd1,
        StDone    = 2'd2
    } cmp_state_e;

    localparam logic [2:0] ResNone = 3'b000;
    localparam logic [2:0] ResEq   = 3'b100;
    localparam logic [2:0] ResLt   = 3'b010;
    localparam logic [2:0] ResGt   = 3'b001;

    function automatic logic [2:0] res_encode(input logic lt, input logic gt);
        logic [2:0] res;
        res = ResEq;
        if (lt) begin
            res = ResLt;
        end else if (gt) begin
            res = ResGt;
        end
        return res;
    endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module comparator_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    output logic             o_eq,
    output logic             o_lt,
    output logic             o_gt
);

    always_comb begin
        o_eq = (i_a == i_b);
        o_lt = (i_a < i_b);
        o_gt = (i_a > i_b);
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: scans operands MSB-first, DIGIT bits per cycle,
// and stops at the first differing digit.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_gt_b
);

    localparam int unsigned NumDigits = WIDTH / DIGIT;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [WIDTH-1:0] MsbMask = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CntW-1:0]  LastCnt = CntW'(NumDigits - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_magnitude_comparator: WIDTH must be >= 2");
    end
    if (DIGIT < 1) begin : g_bad_digit
        $error("serial_magnitude_comparator: DIGIT must be >= 1");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
        $error("serial_magnitude_comparator: DIGIT must divide WIDTH");
    end

    cmp_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CntW-1:0]  r_cnt;
    logic             r_done;
    logic [2:0]       r_res;

    logic w_eq;
    logic w_lt;
    logic w_gt;
    logic w_last;

    comparator_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a  (r_a[WIDTH-1 -: DIGIT]),
        .i_b  (r_b[WIDTH-1 -: DIGIT]),
        .o_eq (w_eq),
        .o_lt (w_lt),
        .o_gt (w_gt)
    );

    assign w_last = (r_cnt == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_res   <= ResNone;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Flipping the sign bit maps two's-complement order onto unsigned order.
                        r_a     <= signed_mode ? (a ^ MsbMask) : a;
                        r_b     <= signed_mode ? (b ^ MsbMask) : b;
                        r_cnt   <= '0;
                        r_state <= StCompare;
                    end
                end
                StCompare: begin
                    if (!w_eq) begin
                        r_res   <= res_encode(w_lt, w_gt);
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else if (w_last) begin
                        r_res   <= ResEq;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_a   <= r_a << DIGIT;
                        r_b   <= r_b << DIGIT;
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy                     = (r_state != StIdle);
    assign done                     = r_done;
    assign {a_eq_b, a_lt_b, a_gt_b} = r_res;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator (WIDTH=8, DIGIT=2).
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done, a_eq_b, a_lt_b, a_gt_b;
    logic [2:0] res;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    int n_chk = 0;
    int n_bad = 0;
    logic [2:0] prev_res = 3'b000;

    serial_magnitude_comparator #(
        .WIDTH (8),
        .DIGIT (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .a_eq_b      (a_eq_b),
        .a_lt_b      (a_lt_b),
        .a_gt_b      (a_gt_b)
    );

    assign res = {a_eq_b, a_lt_b, a_gt_b};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Caller positions at a negedge; start is captured at the following posedge (E0).
    task automatic run(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tsm, input int exp_lat, input logic [2:0] exp_res);
        int lat;
        int busy_n;
        a = ta;
        b = tb_;
        signed_mode = tsm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Captured operands must be immune to later input changes.
        a = ~ta;
        b = ~tb_;
        signed_mode = ~tsm;
        check({tag, "_hold"}, 32'(res), 32'(prev_res));
        lat = -1;
        busy_n = 0;
        for (int i = 1; i <= 8; i++) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_n), 32'(exp_lat));
        check({tag, "_res"}, 32'(res), 32'(exp_res));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'({busy, done}), 32'b0);
        prev_res = exp_res;
    endtask

    initial begin
        int ndone;
        logic [2:0] got_res;

        #2;
        check("reset_outs", 32'({busy, done, res}), 32'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed: digits MSB-first, latency = first differing digit index + 1.
        run("a5_a5_u", 8'hA5, 8'hA5, 1'b0, 4, EQ);
        @(negedge clk);
        run("80_7f_u", 8'h80, 8'h7F, 1'b0, 1, GT);
        @(negedge clk);
        run("80_7f_s", 8'h80, 8'h7F, 1'b1, 1, LT);
        @(negedge clk);
        // 0x34 = 00 11 01 00, 0x38 = 00 11 10 00 -> differ at digit index 2.
        run("34_38_u", 8'h34, 8'h38, 1'b0, 3, LT);
        @(negedge clk);
        run("34_04_u", 8'h34, 8'h04, 1'b0, 2, GT);
        @(negedge clk);
        run("80_80_s", 8'h80, 8'h80, 1'b1, 4, EQ);
        @(negedge clk);
        run("ff_01_s", 8'hFF, 8'h01, 1'b1, 1, LT);
        @(negedge clk);
        run("01_02_u", 8'h01, 8'h02, 1'b0, 4, LT);
        @(negedge clk);
        run("03_02_u", 8'h03, 8'h02, 1'b0, 4, GT);

        // Starts during COMPARE and during DONE must both be dropped.
        @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        got_res = 3'b000;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            a = 8'hFF;
            b = 8'h00;
            if (done) begin
                ndone++;
                got_res = res;
            end
            start = done || (i == 1);
        end
        start = 1'b0;
        check("drop_ndone", 32'(ndone), 32'd1);
        check("drop_res", 32'(got_res), 32'(EQ));
        check("drop_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of an equal-operand compare.
        @(negedge clk);
        a = 8'hA5;
        b = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_outs", 32'({busy, done, res}), 32'b0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_nodone", 32'(ndone), 32'd0);
        prev_res = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 8'h80, 8'h7F, 1'b0, 1, GT);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
